// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each result producer owns a 2-entry FIFO of
// {lock index, result}. A round-robin arbiter pops one head per cycle into a
// registered CDB broadcast. Flush discards buffered and in-flight results.
module cdb_arbiter #(
  parameter int N_REQ   = 3,
  parameter int LOCK_W  = 5,
  parameter int DATA_W  = 32,
  parameter int NO_LOCK = 0,
  localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*LOCK_W-1:0]   req_index,
  input  logic [N_REQ*DATA_W-1:0]   req_result,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [LOCK_W-1:0]         cdb_index,
  output logic [DATA_W-1:0]         cdb_result,
  output logic [SRC_W-1:0]          cdb_src
);

  localparam logic [LOCK_W-1:0] IDLE_IDX = LOCK_W'(NO_LOCK);

  logic [LOCK_W-1:0] idx_mem [N_REQ][2];
  logic [DATA_W-1:0] res_mem [N_REQ][2];
  logic [1:0]        cnt     [N_REQ];
  logic [N_REQ-1:0]  rd_ptr;
  logic [N_REQ-1:0]  wr_ptr;
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  rr_next;
  logic [SRC_W-1:0]  grant;
  logic              grant_vld;
  logic [N_REQ-1:0]  push;
  logic [N_REQ-1:0]  pop;
  logic [LOCK_W-1:0] head_idx;
  logic [DATA_W-1:0] head_res;

  // Ready comes from registered occupancy only; NO_LOCK requests never enqueue.
  always_comb begin
    req_ready = '0;
    push      = '0;
    pop       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (cnt[i] != 2'd2);
      push[i]      = req_valid[i] && (cnt[i] != 2'd2) &&
                     (req_index[i*LOCK_W +: LOCK_W] != IDLE_IDX);
      pop[i]       = grant_vld && (grant == SRC_W'(i));
    end
  end

  // Round-robin search from rr_ptr over non-empty FIFOs, wrapping modulo N_REQ.
  always_comb begin
    int j;
    logic [SRC_W-1:0] cand;
    j         = 0;
    cand      = '0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      cand = SRC_W'(j);
      if (!grant_vld && (cnt[cand] != 2'd0)) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
    rr_next  = (int'(grant) == N_REQ - 1) ? '0 : grant + SRC_W'(1);
    head_idx = idx_mem[grant][rd_ptr[grant]];
    head_res = res_mem[grant][rd_ptr[grant]];
  end

  // FIFO occupancy and pointers; a push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= 2'd0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 2'd1;
          2'b01:   cnt[i] <= cnt[i] - 2'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // FIFO payload storage; contents are only meaningful under a valid count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (push[i] && !rst && !flush) begin
        idx_mem[i][wr_ptr[i]] <= req_index[i*LOCK_W +: LOCK_W];
        res_mem[i][wr_ptr[i]] <= req_result[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin pointer moves past the winner; flush leaves it where it is.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_vld && !flush) begin
      rr_ptr <= rr_next;
    end
  end

  // Registered CDB broadcast; idle bus carries NO_LOCK and a zero result.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cdb_valid  <= 1'b0;
      cdb_index  <= IDLE_IDX;
      cdb_result <= '0;
      cdb_src    <= '0;
    end else if (grant_vld) begin
      cdb_valid  <= 1'b1;
      cdb_index  <= head_idx;
      cdb_result <= head_res;
      cdb_src    <= grant;
    end else begin
      cdb_valid  <= 1'b0;
      cdb_index  <= IDLE_IDX;
      cdb_result <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-derived expected broadcasts.
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int LW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*LW-1:0] req_index;
  logic [N*DW-1:0] req_result;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [LW-1:0]   cdb_index;
  logic [DW-1:0]   cdb_result;
  logic [1:0]      cdb_src;

  int n_vec = 0;
  int n_bad = 0;

  cdb_arbiter #(.N_REQ(N), .LOCK_W(LW), .DATA_W(DW), .NO_LOCK(0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_index(req_index), .req_result(req_result),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_index(cdb_index),
    .cdb_result(cdb_result), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [LW-1:0] idx,
                         input logic [DW-1:0] res);
    req_valid[i]          = v;
    req_index[i*LW +: LW] = idx;
    req_result[i*DW +: DW] = res;
  endtask

  task automatic clr();
    req_valid  = '0;
    req_index  = '0;
    req_result = '0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    clr();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v"},   64'(cdb_valid),  64'd0);
    chk({tag, "_idx"}, 64'(cdb_index),  64'd0);
    chk({tag, "_res"}, 64'(cdb_result), 64'd0);
  endtask

  initial begin
    logic [LW-1:0] seq2 [3];
    logic [LW-1:0] got2 [$];
    int   p2, last_g, max_gap, nvalid;
    bit   acc, saw_nr;

    seq2[0] = 5'd7; seq2[1] = 5'd8; seq2[2] = 5'd9;

    // Reset then idle
    rst = 1'b1; flush = 1'b0; clr();
    step();
    step();
    chk_idle("rst");
    chk("rst_src", 64'(cdb_src), 64'd0);
    chk("rst_rdy", 64'(req_ready), 64'h7);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_idle("idle");
      chk("idle_rdy", 64'(req_ready), 64'h7);
    end

    // Single request from requester 0
    set_req(0, 1'b1, 5'd5, 32'h0000_00AA);
    step();
    clr();
    chk("single_early_v", 64'(cdb_valid), 64'd0);
    step();
    chk("single_v",   64'(cdb_valid),  64'd1);
    chk("single_idx", 64'(cdb_index),  64'd5);
    chk("single_res", 64'(cdb_result), 64'hAA);
    chk("single_src", 64'(cdb_src),    64'd0);
    step();
    chk_idle("single_after");

    // Three-way contention from rr_ptr = 0
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, LW'(i + 1), DW'(32'h100 + i));
    step();
    clr();
    chk("cont_early_v", 64'(cdb_valid), 64'd0);
    for (int i = 0; i < N; i++) begin
      step();
      chk("cont_v",   64'(cdb_valid),  64'd1);
      chk("cont_src", 64'(cdb_src),    64'(i));
      chk("cont_idx", 64'(cdb_index),  64'(i + 1));
      chk("cont_res", 64'(cdb_result), 64'(32'h100 + i));
    end
    chk("cont_rr", 64'(dut.rr_ptr), 64'd0);
    step();
    chk_idle("cont_after");

    // Backpressure on requester 2 while 0 and 1 stream
    do_reset();
    p2 = 0; last_g = 1; max_gap = 0; nvalid = 0; saw_nr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_req(0, 1'b1, 5'd10, DW'(32'h1000 + i));
      set_req(1, 1'b1, 5'd11, DW'(32'h2000 + i));
      if (p2 < 3) set_req(2, 1'b1, seq2[p2], DW'(32'h3000 + p2));
      else        set_req(2, 1'b0, 5'd0, 32'h0);
      acc = req_valid[2] && req_ready[2];
      if (req_valid[2] && !req_ready[2]) saw_nr = 1'b1;
      step();
      if (acc) p2++;
      if (i >= 1 && cdb_valid) nvalid++;
      if (cdb_valid && cdb_src == 2'd2) begin
        got2.push_back(cdb_index);
        if ((i + 1) - last_g > max_gap) max_gap = (i + 1) - last_g;
        last_g = i + 1;
      end
    end
    clr();
    chk("bp_not_ready_seen", 64'(saw_nr), 64'd1);
    chk("bp_all_accepted",   64'(p2), 64'd3);
    chk("bp_src2_count",     64'(got2.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got2.size()) chk("bp_src2_order", 64'(got2[k]), 64'(seq2[k]));
      else                 chk("bp_src2_order", 64'hFFFF, 64'(seq2[k]));
    end
    chk("bp_fair_gap_le3", 64'(max_gap <= 3), 64'd1);
    chk("bp_throughput",   64'(nvalid), 64'd19);

    // Flush mid-operation with FIFOs full
    do_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, LW'(20 + i), DW'(32'h500 + i));
      step();
    end
    clr();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'd30, 32'hDEAD);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clr();
    chk_idle("flush");
    chk("flush_src", 64'(cdb_src), 64'd0);
    chk("flush_rdy", 64'(req_ready), 64'h7);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_idle("flush_after");
      chk("flush_after_rdy", 64'(req_ready), 64'h7);
    end

    // NO_LOCK filter on requester 1
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'h1234_5678);
    step();
    chk("nolock_cnt1", 64'(dut.cnt[1]), 64'd0);
    chk("nolock_rdy",  64'(req_ready), 64'h7);
    step();
    clr();
    chk_idle("nolock_a");
    step();
    chk_idle("nolock_b");
    chk("nolock_cnt1_end", 64'(dut.cnt[1]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between N functional-unit result producers (ALU, branch unit, load/store unit).
- Each producer pushes {rob lock index, result} into a private 2-entry FIFO.
- A round-robin arbiter pops one entry per cycle and drives a registered CDB broadcast, which every reservation station and the register file snoop.
- A flush input (branch mispredict) discards all buffered and in-flight results.

Parameters:
- N_REQ, 3, number of requesters; requester 0 = ALU, 1 = branch, 2 = LSU.
- LOCK_W, 5, width of the reorder/lock index (matches Reg_Lock_Width).
- DATA_W, 32, result width (matches Data_Width).
- NO_LOCK, 0, index value meaning "no lock / idle bus" (matches Reg_No_Lock).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush; synchronous, same effect as rst on FIFOs and outputs.
- req_valid  in  N_REQ  per-requester result valid.
- req_index  in  N_REQ*LOCK_W  per-requester lock index; requester i occupies bits [i*LOCK_W +: LOCK_W].
- req_result  in  N_REQ*DATA_W  per-requester result; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  FIFO i not full; driven combinationally from registered occupancy only.
- cdb_valid  out  1  registered; broadcast valid this cycle.
- cdb_index  out  LOCK_W  registered broadcast lock index; NO_LOCK whenever cdb_valid=0.
- cdb_result  out  DATA_W  registered broadcast result; 0 whenever cdb_valid=0.
- cdb_src  out  $clog2(N_REQ)  registered id of the requester that owns the current broadcast.

Behaviour:
- Reset (rst=1 at an edge): all FIFOs empty (count=0, rd/wr pointers=0); rr_ptr=0; cdb_valid=0, cdb_index=NO_LOCK, cdb_result=0, cdb_src=0. After reset, req_ready is all ones.
- Push rule: FIFO i is written at an edge iff req_valid[i] && req_ready[i] && req_index[i] != NO_LOCK.
  - A valid request carrying NO_LOCK is dropped silently.
  - A valid request while req_ready[i]=0 is the requester's violation; it is ignored and no entry is written.
- Ready: req_ready[i] = (count_i != 2). It is not raised by a same-cycle pop, so there is no full-FIFO pass-through.
- Arbitration (combinational, every cycle):
  - Candidates are the non-empty FIFOs.
  - Search starts at rr_ptr and wraps modulo N_REQ; the first candidate found is the grant.
  - The grant's head entry is popped at the edge.
  - rr_ptr <= (grant+1) mod N_REQ. rr_ptr is unchanged if there is no grant.
- Output register, at each edge:
  - With a grant: cdb_valid<=1, cdb_index<=head.index, cdb_result<=head.result, cdb_src<=grant.
  - Without a grant: cdb_valid<=0, cdb_index<=NO_LOCK, cdb_result<=0, cdb_src holds.
- Latency: a request accepted at edge t, going to an empty FIFO with no contention, appears on the CDB during the cycle after edge t+1. Minimum is 2 cycles from the request cycle.
- Throughput: 1 broadcast per cycle whenever any FIFO is non-empty.
- Fairness: a non-empty FIFO is granted within N_REQ consecutive cycles.
- Simultaneous push and pop on the same FIFO (count 1): count stays 1; the pointers both advance mod 2.
- Simultaneous push and pop on an empty FIFO: impossible. An empty FIFO is not a candidate; the pushed entry waits one cycle.
- Flush:
  - flush=1 at an edge is identical to rst for FIFO contents and output registers, so the next cycle has cdb_valid=0.
  - rr_ptr is not reset by flush.
  - Pushes presented in the flush cycle are discarded.
  - rst has priority over flush.
- Ordering: per requester, results leave in the order they were accepted. There is no ordering guarantee across requesters.

Test Plan:
- Reset then idle: hold rst 2 cycles, then release. Required: cdb_valid=0, cdb_index=0, cdb_result=0, req_ready=3'b111 every cycle.
- Single request: req 0 presents index 5, result 32'h0000_00AA for one cycle. Required: exactly one broadcast, 2 cycles later, with cdb_index=5, cdb_result=0xAA, cdb_src=0; idle afterwards.
- Three-way contention: all 3 requesters push in the same cycle (indices 1, 2, 3) with rr_ptr=0. Required: broadcasts on 3 consecutive cycles in order src 0, 1, 2; rr_ptr ends at 0.
- Backpressure: req 2 pushes indices 7, 8, 9 on consecutive cycles while reqs 0 and 1 stream continuously. Required: req_ready[2]=0 when its FIFO holds 2 entries; the push of 9 is held off until ready; CDB order for src 2 is 7, 8, 9; src 2 is granted at least every 3 cycles.
- Flush mid-operation: fill all FIFOs (6 entries), then assert flush for 1 cycle. Required: cdb_valid=0 on the following cycle; no stale index reappears; req_ready=3'b111.
- NO_LOCK filter: req 1 is valid with index 0. Required: no enqueue and no broadcast; count_1 stays 0.
